mbe_check_sink: RTL and testbench

- Self-checking result sink for the MBE multiplier bench; the counterpart of the operand source.
- Receives the operand stream that drives both multiplier inputs, plus the multiplier product.
- Aligns each operand with its product and compares the product against an internally computed signed square.
- Counts samples and mismatches, captures the first failing pair, and reports a pass/fail verdict after NSAMPLES checks.

---
 rtl/mbe_check_sink.sv | 99 +++++++++
 tb/tb_mbe_check_sink.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mbe_check_sink.sv
// mbe_check_sink: self-checking sink that compares multiplier products against the signed square of the operand
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   START            single-cycle pulse that begins a run (ignored while BUSY)
//   VIN, OPND        operand valid and operand fed to both multiplier inputs
//   PROD             multiplier product, LAT cycles behind its operand
//   BUSY, DONE, PASS run in progress / run finished / finished with zero mismatches
//   SMP_CNT, ERR_CNT aligned samples checked and mismatches seen in this run
//   FIRST_ERR_OP/PROD operand and received product of the first mismatch
module mbe_check_sink #(
    parameter int N        = 32,
    parameter int LAT      = 0,
    parameter int NSAMPLES = 1000,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             VIN,
    input  logic [N-1:0]     OPND,
    input  logic [2*N-1:0]   PROD,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] SMP_CNT,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [N-1:0]     FIRST_ERR_OP,
    output logic [2*N-1:0]   FIRST_ERR_PROD
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, nxt;
    logic a_v;
    logic [N-1:0] a_op;
    logic [2*N-1:0] op_ext, exp_sq;
    logic hit, mis, last, clr, pass_q;
    // Delay line pairs each operand with the product that emerges LAT cycles later.
    generate
        if (LAT == 0) begin : g_direct
            assign a_v  = VIN;
            assign a_op = OPND;
        end else begin : g_dly
            logic [LAT-1:0] dv;
            logic [N-1:0]   dop [LAT];
            always_ff @(posedge CLK) begin
                if (RST) begin
                    dv <= '0;
                    for (int i = 0; i < LAT; i++) dop[i] <= '0;
                end else begin
                    dv[0]  <= VIN;
                    dop[0] <= OPND;
                    for (int i = 1; i < LAT; i++) begin
                        dv[i]  <= dv[i-1];
                        dop[i] <= dop[i-1];
                    end
                end
            end
            assign a_v  = dv[LAT-1];
            assign a_op = dop[LAT-1];
        end
    endgenerate
    // A signed square always fits in 2N bits, so the truncated product of the sign-extended operand is exact.
    assign op_ext = {{N{a_op[N-1]}}, a_op};
    assign exp_sq = op_ext * op_ext;
    assign hit  = (state == S_RUN) && a_v;
    assign mis  = PROD != exp_sq;
    assign last = SMP_CNT == CNT_W'(NSAMPLES - 1);
    assign clr  = START && (state != S_RUN);
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= nxt;
    end
    always_comb begin
        nxt = (state == S_RUN) ? ((hit && last) ? S_DONE : S_RUN)
                               : (START ? S_RUN : state);
    end
    always_comb begin
        BUSY = state == S_RUN;
        DONE = state == S_DONE;
        PASS = pass_q;
    end
    // ERR_CNT never returns to zero within a run, so zero marks "no mismatch captured yet".
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            SMP_CNT        <= '0;
            ERR_CNT        <= '0;
            FIRST_ERR_OP   <= '0;
            FIRST_ERR_PROD <= '0;
            pass_q         <= 1'b0;
        end else if (hit) begin
            SMP_CNT <= SMP_CNT + 1'b1;
            if (mis) ERR_CNT <= (&ERR_CNT) ? ERR_CNT : ERR_CNT + 1'b1;
            if (mis && ERR_CNT == '0) begin
                FIRST_ERR_OP   <= a_op;
                FIRST_ERR_PROD <= PROD;
            end
            if (last) pass_q <= !mis && ERR_CNT == '0;
        end
    end
endmodule

// File: tb/tb_mbe_check_sink.sv
// tb_mbe_check_sink: table-driven scoreboard bench for mbe_check_sink across three parameter sets
module tb_mbe_check_sink;
    typedef struct {
        bit          busy, done, pass;
        int          smp, err;
        logic [31:0] fop;
        logic [63:0] fprod;
    } exp_t;
    typedef struct {
        bit          rst;
        int          sel;
        bit          start, vin;
        logic [31:0] op;
        logic [63:0] prod;
        exp_t        e;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        start [3];
    logic        vin   [3];
    logic [31:0] opnd  [3];
    logic [63:0] prod  [3];
    logic        busy  [3];
    logic        done  [3];
    logic        pass  [3];
    logic [15:0] smp   [3];
    logic [15:0] err   [3];
    logic [31:0] fop   [3];
    logic [63:0] fprod [3];
    vec_t tbl[$];
    exp_t sb[$];
    int total = 0;
    int passed = 0;
    always #5 clk = ~clk;
    mbe_check_sink #(.N(32), .LAT(0), .NSAMPLES(4), .CNT_W(16)) u_a (
        .CLK(clk), .RST(rst), .START(start[0]), .VIN(vin[0]), .OPND(opnd[0]), .PROD(prod[0]),
        .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .SMP_CNT(smp[0]), .ERR_CNT(err[0]),
        .FIRST_ERR_OP(fop[0]), .FIRST_ERR_PROD(fprod[0]));
    mbe_check_sink #(.N(32), .LAT(2), .NSAMPLES(3), .CNT_W(16)) u_b (
        .CLK(clk), .RST(rst), .START(start[1]), .VIN(vin[1]), .OPND(opnd[1]), .PROD(prod[1]),
        .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .SMP_CNT(smp[1]), .ERR_CNT(err[1]),
        .FIRST_ERR_OP(fop[1]), .FIRST_ERR_PROD(fprod[1]));
    mbe_check_sink #(.N(32), .LAT(0), .NSAMPLES(3), .CNT_W(16)) u_c (
        .CLK(clk), .RST(rst), .START(start[2]), .VIN(vin[2]), .OPND(opnd[2]), .PROD(prod[2]),
        .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .SMP_CNT(smp[2]), .ERR_CNT(err[2]),
        .FIRST_ERR_OP(fop[2]), .FIRST_ERR_PROD(fprod[2]));
    task automatic v(input bit r, input int s, input bit st, input bit vi, input logic [31:0] op,
                     input logic [63:0] pr, input bit b, input bit d, input bit p, input int sm,
                     input int er, input logic [31:0] fo, input logic [63:0] fp);
        vec_t x;
        x.rst = r; x.sel = s; x.start = st; x.vin = vi; x.op = op; x.prod = pr;
        x.e.busy = b; x.e.done = d; x.e.pass = p; x.e.smp = sm; x.e.err = er;
        x.e.fop = fo; x.e.fprod = fp;
        tbl.push_back(x);
    endtask
    task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL row %0d %s: got %0h want %0h", row, nm, act, want);
    endtask
    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0; vin[k] = 1'b0; opnd[k] = '0; prod[k] = '0;
        end
    endtask
    initial begin
        exp_t e;
        int s;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_busy", -1, busy[k], 0);
            chk("reset_done", -1, done[k], 0);
            chk("reset_pass", -1, pass[k], 0);
            chk("reset_smp", -1, smp[k], 0);
            chk("reset_err", -1, err[k], 0);
            chk("reset_fop", -1, fop[k], 0);
            chk("reset_fprod", -1, fprod[k], 0);
        end
        // LAT=0, NSAMPLES=4: clean run, error run with mid-run START, reset mid-run
        v(1,0,0,0,0,0,                       0,0,0,0,0,0,0);
        v(0,0,0,1,3,9,                       0,0,0,0,0,0,0);
        v(0,0,1,0,0,0,                       1,0,0,0,0,0,0);
        v(0,0,0,1,3,9,                       1,0,0,1,0,0,0);
        v(0,0,0,1,32'hFFFFFFFE,4,            1,0,0,2,0,0,0);
        v(0,0,0,1,32'h7FFFFFFF,64'h3FFFFFFF00000001, 1,0,0,3,0,0,0);
        v(0,0,0,1,32'h80000000,64'h4000000000000000, 0,1,1,4,0,0,0);
        v(0,0,0,1,3,10,                      0,1,1,4,0,0,0);
        v(0,0,1,0,0,0,                       1,0,0,0,0,0,0);
        v(0,0,0,1,3,10,                      1,0,0,1,1,3,10);
        v(0,0,0,1,32'hFFFFFFFE,5,            1,0,0,2,2,3,10);
        v(0,0,1,1,32'h7FFFFFFF,64'h3FFFFFFF00000001, 1,0,0,3,2,3,10);
        v(0,0,0,1,32'h80000000,64'h4000000000000000, 0,1,0,4,2,3,10);
        v(0,0,0,0,0,0,                       0,1,0,4,2,3,10);
        v(0,0,1,0,0,0,                       1,0,0,0,0,0,0);
        v(0,0,0,1,3,9,                       1,0,0,1,0,0,0);
        v(0,0,0,1,32'hFFFFFFFE,7,            1,0,0,2,1,32'hFFFFFFFE,7);
        v(1,0,1,1,32'h7FFFFFFF,64'h3FFFFFFF00000001, 0,0,0,0,0,0,0);
        v(0,0,0,1,3,9,                       0,0,0,0,0,0,0);
        v(0,0,0,1,3,10,                      0,0,0,0,0,0,0);
        v(0,0,1,0,0,0,                       1,0,0,0,0,0,0);
        v(0,0,0,1,3,9,                       1,0,0,1,0,0,0);
        v(0,0,0,1,32'hFFFFFFFE,4,            1,0,0,2,0,0,0);
        v(0,0,0,1,32'h7FFFFFFF,64'h3FFFFFFF00000001, 1,0,0,3,0,0,0);
        v(0,0,0,1,32'h80000000,64'h4000000000000000, 0,1,1,4,0,0,0);
        v(0,0,1,1,3,10,                      1,0,0,0,0,0,0);
        // LAT=0, NSAMPLES=3: VIN gaps stall counting
        v(0,2,1,0,0,0,                       1,0,0,0,0,0,0);
        v(0,2,0,1,2,4,                       1,0,0,1,0,0,0);
        v(0,2,0,0,5,0,                       1,0,0,1,0,0,0);
        v(0,2,0,0,0,0,                       1,0,0,1,0,0,0);
        v(0,2,0,1,32'hFFFFFFFF,1,            1,0,0,2,0,0,0);
        v(0,2,0,0,0,0,                       1,0,0,2,0,0,0);
        v(0,2,0,1,32'h00010000,64'h100000000, 0,1,1,3,0,0,0);
        // LAT=2, NSAMPLES=3: products aligned, then products too early
        v(0,1,1,0,0,0,                       1,0,0,0,0,0,0);
        v(0,1,0,1,5,0,                       1,0,0,0,0,0,0);
        v(0,1,0,1,6,0,                       1,0,0,0,0,0,0);
        v(0,1,0,1,7,25,                      1,0,0,1,0,0,0);
        v(0,1,0,0,0,36,                      1,0,0,2,0,0,0);
        v(0,1,0,0,0,49,                      0,1,1,3,0,0,0);
        v(0,1,0,0,0,0,                       0,1,1,3,0,0,0);
        v(0,1,0,0,0,0,                       0,1,1,3,0,0,0);
        v(0,1,1,0,0,0,                       1,0,0,0,0,0,0);
        v(0,1,0,1,5,25,                      1,0,0,0,0,0,0);
        v(0,1,0,1,6,36,                      1,0,0,0,0,0,0);
        v(0,1,0,1,7,49,                      1,0,0,1,1,5,49);
        v(0,1,0,0,0,0,                       1,0,0,2,2,5,49);
        v(0,1,0,0,0,0,                       0,1,0,3,3,5,49);
        foreach (tbl[i]) begin
            idle_inputs();
            s = tbl[i].sel;
            rst = tbl[i].rst;
            start[s] = tbl[i].start;
            vin[s]   = tbl[i].vin;
            opnd[s]  = tbl[i].op;
            prod[s]  = tbl[i].prod;
            sb.push_back(tbl[i].e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("busy", i, busy[s], e.busy);
            chk("done", i, done[s], e.done);
            chk("pass", i, pass[s], e.pass);
            chk("smp_cnt", i, smp[s], 64'(e.smp));
            chk("err_cnt", i, err[s], 64'(e.err));
            chk("first_err_op", i, fop[s], e.fop);
            chk("first_err_prod", i, fprod[s], e.fprod);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
